// File: rtl/sent_tx_pulse_gen.sv
// SENT transmitter frame encoder: sync, status, six data nibbles and CRC as tick-timed pulses.
// Define SENT_TX_PAUSE_EN to pad every frame with a pause pulse to exactly FRAME_TICKS ticks.
module sent_tx_pulse_gen #(
  parameter int LOW_TICKS   = 5,
  parameter int SYNC_TICKS  = 56,
  parameter int FRAME_TICKS = 284
) (
  input  logic        clk_tx,
  input  logic        reset_tx,
  input  logic        ticks_i,
  input  logic        load_i,
  input  logic [3:0]  status_i,
  input  logic [23:0] data_i,
  output logic        ready_o,
  output logic        sent_o,
  output logic [3:0]  crc_o,
  output logic        frame_done_o
);

  // Counter width follows the longest possible pulse/frame count.
  localparam int CW = $clog2(FRAME_TICKS + 1);
  localparam logic [CW-1:0] C_LOW  = CW'(LOW_TICKS);
  localparam logic [CW-1:0] C_SYNC = CW'(SYNC_TICKS);
  localparam logic [CW-1:0] C_NIB0 = CW'(12);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_SYNC  = 3'd2;
  localparam logic [2:0] ST_NIB   = 3'd3;
`ifdef SENT_TX_PAUSE_EN
  localparam logic [2:0] ST_PAUSE = 3'd4;
  localparam logic [CW-1:0] C_FRAME = CW'(FRAME_TICKS);
`endif

  logic          r_ticks_d;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_nib_idx;
  logic [3:0]    r_status;
  logic [23:0]   r_data;
  logic [3:0]    r_crc;
  logic          r_sent;
  logic          r_ready;
  logic          r_frame_done;
`ifdef SENT_TX_PAUSE_EN
  logic [CW-1:0] r_acc;
`endif

  logic          w_tick_evt;
  logic          w_accept;
  logic [3:0]    w_crc;
  logic [3:0]    w_nib;
  logic [CW-1:0] w_nib_len;
  logic          w_pulse_end;

  function automatic logic [3:0] crc_tab(input logic [3:0] idx);
    logic [3:0] v;
    case (idx)
      4'd0:    v = 4'd0;
      4'd1:    v = 4'd13;
      4'd2:    v = 4'd7;
      4'd3:    v = 4'd10;
      4'd4:    v = 4'd14;
      4'd5:    v = 4'd3;
      4'd6:    v = 4'd9;
      4'd7:    v = 4'd4;
      4'd8:    v = 4'd1;
      4'd9:    v = 4'd12;
      4'd10:   v = 4'd6;
      4'd11:   v = 4'd11;
      4'd12:   v = 4'd15;
      4'd13:   v = 4'd2;
      4'd14:   v = 4'd8;
      default: v = 4'd5;
    endcase
    return v;
  endfunction

  // Handshake: a frame is accepted on a clk_tx edge where load_i and ready_o are both high;
  // ready_o drops the next cycle and returns high together with frame_done_o.
  assign w_tick_evt = ticks_i & ~r_ticks_d;
  assign w_accept   = load_i & r_ready;

  // CRC over d0..d5 from seed 5 plus one trailing zero nibble; status is excluded.
  always_comb begin
    logic [3:0] v_crc;
    v_crc = 4'h5;
    for (int i = 5; i >= 0; i--) begin
      v_crc = crc_tab(v_crc) ^ data_i[i*4 +: 4];
    end
    w_crc = crc_tab(v_crc);
  end

  always_comb begin
    w_nib = r_status;
    case (r_nib_idx)
      3'd0:    w_nib = r_status;
      3'd1:    w_nib = r_data[23:20];
      3'd2:    w_nib = r_data[19:16];
      3'd3:    w_nib = r_data[15:12];
      3'd4:    w_nib = r_data[11:8];
      3'd5:    w_nib = r_data[7:4];
      3'd6:    w_nib = r_data[3:0];
      default: w_nib = r_crc;
    endcase
  end

  assign w_nib_len = C_NIB0 + {{(CW-4){1'b0}}, w_nib};

  always_comb begin
    w_pulse_end = 1'b0;
    case (r_state)
      ST_SYNC:  w_pulse_end = (r_cnt == C_SYNC);
      ST_NIB:   w_pulse_end = (r_cnt == w_nib_len);
`ifdef SENT_TX_PAUSE_EN
      ST_PAUSE: w_pulse_end = (r_acc + CW'(1) == C_FRAME);
`endif
      default:  w_pulse_end = 1'b0;
    endcase
  end

  always_ff @(posedge clk_tx) begin
    if (reset_tx) begin
      r_ticks_d    <= 1'b0;
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_nib_idx    <= '0;
      r_status     <= '0;
      r_data       <= '0;
      r_crc        <= '0;
      r_sent       <= 1'b1;
      r_ready      <= 1'b1;
      r_frame_done <= 1'b0;
`ifdef SENT_TX_PAUSE_EN
      r_acc        <= '0;
`endif
    end else begin
      r_ticks_d    <= ticks_i;
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_status <= status_i;
            r_data   <= data_i;
            r_crc    <= w_crc;
            r_ready  <= 1'b0;
            r_state  <= ST_ARM;
          end
        end
        ST_ARM: begin
          if (w_tick_evt) begin
            r_sent    <= 1'b0;
            r_cnt     <= CW'(1);
            r_nib_idx <= '0;
            r_state   <= ST_SYNC;
`ifdef SENT_TX_PAUSE_EN
            r_acc     <= '0;
`endif
          end
        end
        ST_SYNC, ST_NIB
`ifdef SENT_TX_PAUSE_EN
        , ST_PAUSE
`endif
        : begin
          if (w_tick_evt) begin
`ifdef SENT_TX_PAUSE_EN
            r_acc <= r_acc + CW'(1);
`endif
            if (w_pulse_end) begin
              // Default: the next pulse starts on this same tick.
              r_sent <= 1'b0;
              r_cnt  <= CW'(1);
              if (r_state == ST_SYNC) begin
                r_state   <= ST_NIB;
                r_nib_idx <= '0;
              end else if (r_state == ST_NIB && r_nib_idx != 3'd7) begin
                r_nib_idx <= r_nib_idx + 3'd1;
`ifdef SENT_TX_PAUSE_EN
              end else if (r_state == ST_NIB) begin
                r_state <= ST_PAUSE;
`endif
              end else begin
                r_sent       <= 1'b1;
                r_cnt        <= '0;
                r_state      <= ST_IDLE;
                r_ready      <= 1'b1;
                r_frame_done <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
              if (r_cnt == C_LOW) r_sent <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready_o      = r_ready;
  assign sent_o       = r_sent;
  assign crc_o        = r_crc;
  assign frame_done_o = r_frame_done;

endmodule

// File: tb/tb_sent_tx_pulse_gen.sv
// Directed bench for sent_tx_pulse_gen: pulse lengths, low phases, CRC, busy load, back-to-back,
// tick-coincident load and mid-frame reset. Expectations follow SENT_TX_PAUSE_EN when defined.
module tb_sent_tx_pulse_gen;

  localparam int TICK_CLKS = 50;
  localparam int FRAME_T   = 284;

  logic        clk_tx = 1'b0;
  logic        reset_tx;
  logic        ticks_i = 1'b0;
  logic        load_i;
  logic [3:0]  status_i;
  logic [23:0] data_i;
  logic        ready_o;
  logic        sent_o;
  logic [3:0]  crc_o;
  logic        frame_done_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tph = 0;
  int fd_cnt = 0;
  logic prev_sent = 1'b1;
  int fall_q[$];
  int rise_q[$];
  logic [8:0] exp_q[$];

  sent_tx_pulse_gen dut (
    .clk_tx       (clk_tx),
    .reset_tx     (reset_tx),
    .ticks_i      (ticks_i),
    .load_i       (load_i),
    .status_i     (status_i),
    .data_i       (data_i),
    .ready_o      (ready_o),
    .sent_o       (sent_o),
    .crc_o        (crc_o),
    .frame_done_o (frame_done_o)
  );

  // Clock, cycle counter and a tick generator at divide 50 (25 high / 25 low).
  always #5 clk_tx = ~clk_tx;
  always @(posedge clk_tx) cyc <= cyc + 1;
  always @(negedge clk_tx) begin
    tph = (tph == TICK_CLKS - 1) ? 0 : tph + 1;
    ticks_i = (tph < TICK_CLKS / 2);
  end

  // Line monitor: edge times in cycles, frame_done pulse count.
  always @(negedge clk_tx) begin
    if (prev_sent === 1'b1 && sent_o === 1'b0) fall_q.push_back(cyc);
    if (prev_sent === 1'b0 && sent_o === 1'b1) rise_q.push_back(cyc);
    prev_sent = sent_o;
    if (frame_done_o === 1'b1) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_frame(input logic [3:0] st, input logic [23:0] d);
    status_i = st;
    data_i   = d;
    load_i   = 1'b1;
    @(negedge clk_tx);
    load_i   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int done_cyc);
    int n;
    n = 0;
    done_cyc = -1;
    while (frame_done_o !== 1'b1 && n < budget) begin
      @(negedge clk_tx);
      n++;
    end
    if (frame_done_o === 1'b1) done_cyc = cyc;
    check({tag, "_done_seen"}, 32'(frame_done_o), 1);
  endtask

  task automatic build_exp(input logic [3:0] st, input logic [23:0] d, input logic [3:0] crc);
    int sum;
    exp_q.delete();
    exp_q.push_back(9'd56);
    exp_q.push_back(9'(12 + int'(st)));
    for (int i = 5; i >= 0; i--) exp_q.push_back(9'(12 + int'(d[i*4 +: 4])));
    exp_q.push_back(9'(12 + int'(crc)));
    sum = 0;
    foreach (exp_q[i]) sum += int'(exp_q[i]);
`ifdef SENT_TX_PAUSE_EN
    exp_q.push_back(9'(FRAME_T - sum));
`endif
  endtask

  task automatic check_frame(input string tag, input int done_cyc, input int exp_total);
    int n;
    int end_c;
    n = fall_q.size();
    check({tag, "_pulse_count"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      end_c = (i + 1 < n) ? fall_q[i+1] : done_cyc;
      check($sformatf("%s_len%0d", tag, i), end_c - fall_q[i], int'(exp_q[i]) * TICK_CLKS);
    end
    for (int i = 0; i < n && i < rise_q.size(); i++) begin
      check($sformatf("%s_low%0d", tag, i), rise_q[i] - fall_q[i], 5 * TICK_CLKS);
    end
    check({tag, "_frame_len"}, done_cyc - ((n > 0) ? fall_q[0] : 0), exp_total * TICK_CLKS);
  endtask

  initial begin
    int done_c;
    int done_d;
    int fd0;
    int t_cyc;
    int n;
    reset_tx = 1'b1;
    load_i   = 1'b0;
    status_i = '0;
    data_i   = '0;
    repeat (3) @(negedge clk_tx);
    check("rst_sent", 32'(sent_o), 1);
    check("rst_ready", 32'(ready_o), 1);
    check("rst_crc", 32'(crc_o), 0);
    check("rst_done", 32'(frame_done_o), 0);
    reset_tx = 1'b0;
    repeat (2) @(negedge clk_tx);

    // Frame A: all-zero data.
    fall_q.delete(); rise_q.delete(); fd0 = fd_cnt;
    build_exp(4'h0, 24'h000000, 4'd5);
    load_frame(4'h0, 24'h000000);
    check("a_ready_low", 32'(ready_o), 0);
    check("a_crc", 32'(crc_o), 5);
    wait_done("a", 20000, done_c);
    @(negedge clk_tx);
    check("a_done_one_cycle", 32'(frame_done_o), 0);
    check("a_ready_back", 32'(ready_o), 1);
    check("a_line_high", 32'(sent_o), 1);
    check("a_done_count", fd_cnt - fd0, 1);
`ifdef SENT_TX_PAUSE_EN
    check_frame("a", done_c, FRAME_T);
`else
    check_frame("a", done_c, 157);
`endif

    // Frame B: all-ones data, with a load attempt while busy.
    fall_q.delete(); rise_q.delete(); fd0 = fd_cnt;
    build_exp(4'h0, 24'hFFFFFF, 4'd10);
    load_frame(4'h0, 24'hFFFFFF);
    check("b_crc", 32'(crc_o), 10);
    repeat (300) @(negedge clk_tx);
    load_frame(4'h3, 24'h123456);
    check("b_busy_ready", 32'(ready_o), 0);
    check("b_busy_crc", 32'(crc_o), 10);
    wait_done("b", 20000, done_c);
    @(negedge clk_tx);
    check("b_done_count", fd_cnt - fd0, 1);
`ifdef SENT_TX_PAUSE_EN
    check_frame("b", done_c, FRAME_T);
`else
    check_frame("b", done_c, 252);
`endif

    // Frames C and D back-to-back: reload in the frame_done cycle.
    fall_q.delete(); rise_q.delete(); fd0 = fd_cnt;
    build_exp(4'hA, 24'h123456, 4'd2);
    load_frame(4'hA, 24'h123456);
    check("c_crc", 32'(crc_o), 2);
    wait_done("c", 20000, done_c);
    check("c_ready_with_done", 32'(ready_o), 1);
    load_frame(4'h0, 24'h000000);
    check("c_done_count", fd_cnt - fd0, 1);
`ifdef SENT_TX_PAUSE_EN
    check_frame("c", done_c, FRAME_T);
`else
    check_frame("c", done_c, 185);
`endif
    fall_q.delete(); rise_q.delete(); fd0 = fd_cnt;
    build_exp(4'h0, 24'h000000, 4'd5);
    check("d_ready_low", 32'(ready_o), 0);
    check("d_crc", 32'(crc_o), 5);
    wait_done("d", 20000, done_d);
    // Second sync falls one tick after the first frame ended.
    check("d_gap", ((fall_q.size() > 0) ? fall_q[0] : 0) - done_c, TICK_CLKS);
    @(negedge clk_tx);
    check("d_done_count", fd_cnt - fd0, 1);
`ifdef SENT_TX_PAUSE_EN
    check_frame("d", done_d, FRAME_T);
`else
    check_frame("d", done_d, 157);
`endif

    // Frame E: load in the same cycle as a tick event, then reset during sync.
    repeat (7) @(negedge clk_tx);
    fall_q.delete(); rise_q.delete();
    @(posedge ticks_i);
    t_cyc    = cyc;
    status_i = 4'h0;
    data_i   = 24'h000000;
    load_i   = 1'b1;
    @(negedge clk_tx);
    load_i   = 1'b0;
    check("e_ready_low", 32'(ready_o), 0);
    n = 0;
    while (fall_q.size() == 0 && n < 200) begin
      @(negedge clk_tx);
      n++;
    end
    // Tick rise seen at cycle t, next tick at t+50, registered edge one clock later.
    check("e_sync_after_next_tick", ((fall_q.size() > 0) ? fall_q[0] : t_cyc) - t_cyc, TICK_CLKS + 1);
    repeat (2 * TICK_CLKS) @(negedge clk_tx);
    check("e_sync_low", 32'(sent_o), 0);
    fd0 = fd_cnt;
    reset_tx = 1'b1;
    @(negedge clk_tx);
    check("e_rst_sent", 32'(sent_o), 1);
    check("e_rst_ready", 32'(ready_o), 1);
    check("e_rst_done", 32'(frame_done_o), 0);
    check("e_rst_crc", 32'(crc_o), 0);
    repeat (2) @(negedge clk_tx);
    reset_tx = 1'b0;
    fall_q.delete();
    repeat (12 * TICK_CLKS) @(negedge clk_tx);
    check("e_no_line_activity", fall_q.size(), 0);
    check("e_no_frame_done", fd_cnt - fd0, 0);
    check("e_idle_line", 32'(sent_o), 1);
    check("e_idle_ready", 32'(ready_o), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
